// File: rtl/leaf_spine_adapter_pkg.sv
// Shared flit field layout and round-robin helper
// for the leaf side of the leaf/spine link.
package leaf_spine_pkg;

  localparam int DEST_MSB   = 15;
  localparam int DEST_LSB   = 10;
  localparam int GRP_MSB    = 15;
  localparam int GRP_LSB    = 12;
  localparam int NUM_SPINES = 4;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_t;

  // First set bit of mask, searching circularly from ptr.
  function automatic rr_t rr_pick(
    input logic [3:0] mask,
    input logic [1:0] ptr
  );
    rr_t        r;
    logic [1:0] k;
    r = '0;
    for (int i = 0; i < NUM_SPINES; i++) begin
      k = ptr + 2'(i);
      if (!r.found && mask[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/leaf_spine_adapter_fifo.sv
// First-word-fall-through flit FIFO with
// wrap-bit pointers and synchronous reset.
module sync_flit_fifo #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     pop,
  output logic [DWIDTH-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_q, rd_q;
  logic              do_push, do_pop;

  assign count   = wr_q - rd_q;
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/leaf_spine_adapter.sv
// Leaf endpoint: sprays local flits over spine uplinks
// and merges the four downlinks into one local stream.
module leaf_spine_adapter
  import leaf_spine_pkg::*;
#(
  parameter logic [3:0] GROUP_ID      = 4'b0100,
  parameter int         LEAF_ID       = 0,
  parameter int         DWIDTH        = 16,
  parameter int         TX_FIFO_DEPTH = 8,
  parameter int         RX_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        spine_en,
  input  logic [DWIDTH-1:0] loc_tx_data,
  input  logic              loc_tx_valid,
  output logic              loc_tx_ready,
  output logic [DWIDTH-1:0] up1_data,
  output logic [DWIDTH-1:0] up2_data,
  output logic [DWIDTH-1:0] up3_data,
  output logic [DWIDTH-1:0] up4_data,
  output logic              up1_valid,
  output logic              up2_valid,
  output logic              up3_valid,
  output logic              up4_valid,
  input  logic [DWIDTH-1:0] dn1_data,
  input  logic [DWIDTH-1:0] dn2_data,
  input  logic [DWIDTH-1:0] dn3_data,
  input  logic [DWIDTH-1:0] dn4_data,
  input  logic              dn1_valid,
  input  logic              dn2_valid,
  input  logic              dn3_valid,
  input  logic              dn4_valid,
  output logic [DWIDTH-1:0] loc_rx_data,
  output logic              loc_rx_valid,
  input  logic              loc_rx_ready,
  output logic [3:0]        rx_drop,
  output logic              rx_misroute,
  output logic [7:0]        drop_count
);

  localparam logic [5:0] MY_DEST = {GROUP_ID, 2'(LEAF_ID)};

  logic [DWIDTH-1:0] tx_dout;
  logic              tx_full, tx_empty, tx_pop;
  logic [$clog2(TX_FIFO_DEPTH):0] tx_cnt_unused;
  rr_t               tx_pick;
  logic [DWIDTH-1:0] up_data_q [4];
  logic [DWIDTH-1:0] up_data_d [4];
  logic [3:0]        up_valid_q, up_valid_d;
  logic [1:0]        tx_ptr_q, tx_ptr_d;

  assign loc_tx_ready = !tx_full;

  sync_flit_fifo #(
    .DWIDTH(DWIDTH),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk  (clk),
    .reset(reset),
    .push (loc_tx_valid && !tx_full),
    .din  (loc_tx_data),
    .pop  (tx_pop),
    .dout (tx_dout),
    .full (tx_full),
    .empty(tx_empty),
    .count(tx_cnt_unused)
  );

  always_comb begin
    tx_pick    = rr_pick(spine_en, tx_ptr_q);
    tx_pop     = !tx_empty && tx_pick.found;
    up_data_d  = up_data_q;
    up_valid_d = '0;
    tx_ptr_d   = tx_ptr_q;
    if (tx_pop) begin
      up_data_d[tx_pick.idx]  = tx_dout;
      up_valid_d[tx_pick.idx] = 1'b1;
      tx_ptr_d                = tx_pick.idx + 2'd1;
    end
  end

  logic [DWIDTH-1:0] dn_data [4];
  logic [3:0]        dn_valid;
  logic [3:0]        misr, ovf, rx_push, rx_pop;
  logic [3:0]        rx_full, rx_empty;
  logic [DWIDTH-1:0] rx_dout [4];
  logic [$clog2(RX_FIFO_DEPTH):0] rx_cnt_unused [4];

  assign dn_data[0] = dn1_data;
  assign dn_data[1] = dn2_data;
  assign dn_data[2] = dn3_data;
  assign dn_data[3] = dn4_data;
  assign dn_valid   = {dn4_valid, dn3_valid,
                       dn2_valid, dn1_valid};

  for (genvar g = 0; g < NUM_SPINES; g++) begin : g_rx
    assign misr[g] = dn_valid[g] &&
      (dn_data[g][DEST_MSB:DEST_LSB] != MY_DEST);
    // Full is the pre-pop state, so a write racing a pop drops.
    assign ovf[g]     = dn_valid[g] && !misr[g] && rx_full[g];
    assign rx_push[g] = dn_valid[g] && !misr[g] && !rx_full[g];

    sync_flit_fifo #(
      .DWIDTH(DWIDTH),
      .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
      .clk  (clk),
      .reset(reset),
      .push (rx_push[g]),
      .din  (dn_data[g]),
      .pop  (rx_pop[g]),
      .dout (rx_dout[g]),
      .full (rx_full[g]),
      .empty(rx_empty[g]),
      .count(rx_cnt_unused[g])
    );
  end

  rr_t               rx_pick;
  logic              loadable;
  logic [DWIDTH-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [1:0]        rx_ptr_q, rx_ptr_d;
  logic [3:0]        ndrop;
  logic [8:0]        cnt_sum;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [3:0]        rx_drop_q;
  logic              rx_mis_q;

  always_comb begin
    loadable   = !rx_valid_q || loc_rx_ready;
    rx_pick    = rr_pick(~rx_empty, rx_ptr_q);
    rx_pop     = '0;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ptr_d   = rx_ptr_q;
    if (loadable) begin
      rx_valid_d = rx_pick.found;
      if (rx_pick.found) begin
        rx_pop[rx_pick.idx] = 1'b1;
        rx_data_d           = rx_dout[rx_pick.idx];
        rx_ptr_d            = rx_pick.idx + 2'd1;
      end
    end
  end

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NUM_SPINES; i++) begin
      ndrop = ndrop + 4'(misr[i]) + 4'(ovf[i]);
    end
    cnt_sum    = {1'b0, drop_cnt_q} + 9'(ndrop);
    drop_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SPINES; i++) up_data_q[i] <= '0;
      up_valid_q <= '0;
      tx_ptr_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ptr_q   <= '0;
      rx_drop_q  <= '0;
      rx_mis_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      up_data_q  <= up_data_d;
      up_valid_q <= up_valid_d;
      tx_ptr_q   <= tx_ptr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ptr_q   <= rx_ptr_d;
      rx_drop_q  <= ovf;
      rx_mis_q   <= |misr;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign up1_data     = up_data_q[0];
  assign up2_data     = up_data_q[1];
  assign up3_data     = up_data_q[2];
  assign up4_data     = up_data_q[3];
  assign up1_valid    = up_valid_q[0];
  assign up2_valid    = up_valid_q[1];
  assign up3_valid    = up_valid_q[2];
  assign up4_valid    = up_valid_q[3];
  assign loc_rx_data  = rx_data_q;
  assign loc_rx_valid = rx_valid_q;
  assign rx_drop      = rx_drop_q;
  assign rx_misroute  = rx_mis_q;
  assign drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_leaf_spine_adapter.sv
// Bench for leaf_spine_adapter: vector table, directed
// corner sequences and random traffic vs a queue model.
module tb_leaf_spine_adapter;

  localparam logic [5:0] MYD = {4'b0100, 2'd1};

  logic        clk;
  logic        reset;
  logic [3:0]  spine_en;
  logic [15:0] tx_d;
  logic        tx_v, tx_rdy;
  logic [15:0] upd [4];
  logic [3:0]  upv;
  logic [15:0] dnd [4];
  logic [3:0]  dnv;
  logic [15:0] rx_d;
  logic        rx_v, rx_rdy;
  logic [3:0]  drop;
  logic        mis;
  logic [7:0]  dcnt;

  int errs   = 0;
  int checks = 0;

  leaf_spine_adapter #(
    .GROUP_ID(4'b0100),
    .LEAF_ID (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spine_en    (spine_en),
    .loc_tx_data (tx_d),
    .loc_tx_valid(tx_v),
    .loc_tx_ready(tx_rdy),
    .up1_data    (upd[0]),
    .up2_data    (upd[1]),
    .up3_data    (upd[2]),
    .up4_data    (upd[3]),
    .up1_valid   (upv[0]),
    .up2_valid   (upv[1]),
    .up3_valid   (upv[2]),
    .up4_valid   (upv[3]),
    .dn1_data    (dnd[0]),
    .dn2_data    (dnd[1]),
    .dn3_data    (dnd[2]),
    .dn4_data    (dnd[3]),
    .dn1_valid   (dnv[0]),
    .dn2_valid   (dnv[1]),
    .dn3_valid   (dnv[2]),
    .dn4_valid   (dnv[3]),
    .loc_rx_data (rx_d),
    .loc_rx_valid(rx_v),
    .loc_rx_ready(rx_rdy),
    .rx_drop     (drop),
    .rx_misroute (mis),
    .drop_count  (dcnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain queues, observable outputs
  logic [15:0] tq[$];
  logic [15:0] rq[4][$];
  logic [15:0] m_upd [4];
  logic [3:0]  m_upv;
  int          m_txp, m_rxp, m_cnt;
  logic [15:0] m_rxd;
  logic        m_rxv, m_mis;
  logic [3:0]  m_drop;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int         drops;
    logic [3:0] wr;
    bit         acc;
    if (!reset) begin
      tq.delete();
      for (int n = 0; n < 4; n++) begin
        rq[n].delete();
        m_upd[n] = '0;
      end
      m_upv = '0; m_txp = 0; m_rxp = 0;
      m_rxd = '0; m_rxv = 0; m_mis = 0;
      m_drop = '0; m_cnt = 0;
      return;
    end
    acc   = tx_v && (tq.size() < 8);
    m_upv = '0;
    if (tq.size() > 0 && spine_en != 0) begin
      for (int k = 0; k < 4; k++) begin
        int s;
        s = (m_txp + k) % 4;
        if (spine_en[s]) begin
          m_upd[s] = tq.pop_front();
          m_upv[s] = 1'b1;
          m_txp    = (s + 1) % 4;
          break;
        end
      end
    end
    if (acc) tq.push_back(tx_d);
    drops = 0; wr = '0; m_drop = '0; m_mis = 0;
    for (int n = 0; n < 4; n++) begin
      if (dnv[n]) begin
        if (dnd[n][15:10] != MYD) begin
          m_mis = 1; drops++;
        end else if (rq[n].size() == 4) begin
          m_drop[n] = 1'b1; drops++;
        end else begin
          wr[n] = 1'b1;
        end
      end
    end
    if (!m_rxv || rx_rdy) begin
      m_rxv = 0;
      for (int k = 0; k < 4; k++) begin
        int s;
        s = (m_rxp + k) % 4;
        if (rq[s].size() > 0) begin
          m_rxd = rq[s].pop_front();
          m_rxv = 1;
          m_rxp = (s + 1) % 4;
          break;
        end
      end
    end
    for (int n = 0; n < 4; n++)
      if (wr[n]) rq[n].push_back(dnd[n]);
    m_cnt = (m_cnt + drops > 255) ? 255 : m_cnt + drops;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("m_upv", upv, m_upv);
    for (int n = 0; n < 4; n++)
      chk($sformatf("m_up%0d_data", n + 1), upd[n], m_upd[n]);
    chk("m_tx_ready", tx_rdy, tq.size() < 8);
    chk("m_rx_valid", rx_v, m_rxv);
    chk("m_rx_data", rx_d, m_rxd);
    chk("m_rx_drop", drop, m_drop);
    chk("m_misroute", mis, m_mis);
    chk("m_drop_count", dcnt, m_cnt);
  endtask

  function automatic logic [15:0] lane(input logic [3:0] oh);
    return upd[$clog2(oh)];
  endfunction

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [3:0]  ev;
    logic [15:0] ed;
  } vec_t;

  vec_t        tv [10];
  logic [15:0] got[$];

  initial begin
    tv[0] = '{1'b1, 16'h1001, 4'b0000, 16'h0000};
    tv[1] = '{1'b1, 16'h1002, 4'b0001, 16'h1001};
    tv[2] = '{1'b1, 16'h1003, 4'b0010, 16'h1002};
    tv[3] = '{1'b1, 16'h1004, 4'b0100, 16'h1003};
    tv[4] = '{1'b1, 16'h1005, 4'b1000, 16'h1004};
    tv[5] = '{1'b1, 16'h1006, 4'b0001, 16'h1005};
    tv[6] = '{1'b1, 16'h1007, 4'b0010, 16'h1006};
    tv[7] = '{1'b1, 16'h1008, 4'b0100, 16'h1007};
    tv[8] = '{1'b0, 16'h0000, 4'b1000, 16'h1008};
    tv[9] = '{1'b0, 16'h0000, 4'b0000, 16'h0000};

    // Reset with everything asserted
    reset = 0; spine_en = 4'hF; tx_v = 1; tx_d = 16'hAAAA;
    rx_rdy = 1; dnv = 4'hF;
    for (int n = 0; n < 4; n++) dnd[n] = 16'h4400;
    repeat (3) cycle();
    reset = 1; tx_v = 0; dnv = '0;
    cycle();
    chk("rst_tx_ready", tx_rdy, 1'b1);
    chk("rst_rx_valid", rx_v, 1'b0);
    chk("rst_upv", upv, 4'b0000);
    chk("rst_count", dcnt, 8'd0);

    // Spray over all four uplinks
    for (int i = 0; i < 10; i++) begin
      tx_v = tv[i].v; tx_d = tv[i].d;
      cycle();
      chk("spray_v", upv, tv[i].ev);
      if (tv[i].ev != 0)
        chk("spray_d", lane(tv[i].ev), tv[i].ed);
    end

    // Masked spray: up2 / up4 alternate
    spine_en = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      tx_v = (i < 4); tx_d = 16'h2001 + 16'(i);
      cycle();
      if (i >= 1 && i <= 4) begin
        chk("mask_v", upv, (i % 2 == 1) ? 4'b0010 : 4'b1000);
        chk("mask_d", lane(upv), 16'h2000 + 16'(i));
      end
    end

    // Stall with no uplinks, then drain in order
    spine_en = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      tx_v = 1; tx_d = 16'h3001 + 16'(i);
      cycle();
    end
    chk("stall_ready", tx_rdy, 1'b0);
    chk("stall_upv", upv, 4'b0000);
    tx_v = 0; spine_en = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (upv != 0) got.push_back(lane(upv));
    end
    chk("drain_n", got.size(), 8);
    for (int j = 0; j < 8 && j < got.size(); j++)
      chk("drain_d", got[j], 16'h3001 + 16'(j));

    // Merge with backpressure
    rx_rdy = 0; dnv = 4'hF;
    for (int n = 0; n < 4; n++) dnd[n] = 16'h4400 + 16'(n);
    cycle();
    dnv = '0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("hold_v", rx_v, 1'b1);
      chk("hold_d", rx_d, 16'h4400);
    end
    rx_rdy = 1;
    for (int j = 1; j < 4; j++) begin
      cycle();
      chk("merge_d", rx_d, 16'h4400 + 16'(j));
    end
    cycle();
    chk("merge_idle", rx_v, 1'b0);

    // Overflow on dn2
    rx_rdy = 0;
    for (int i = 0; i < 6; i++) begin
      dnv = 4'b0010; dnd[1] = 16'h4410 + 16'(i);
      cycle();
    end
    chk("ovf_drop", drop, 4'b0010);
    chk("ovf_count", dcnt, 8'd1);
    dnv = '0;
    cycle();
    chk("ovf_pulse", drop, 4'b0000);
    chk("ovf_head", rx_d, 16'h4410);
    rx_rdy = 1;
    for (int j = 1; j < 5; j++) begin
      cycle();
      chk("ovf_d", rx_d, 16'h4410 + 16'(j));
    end
    cycle();
    chk("ovf_idle", rx_v, 1'b0);

    // Misroute and saturation
    dnv = 4'b0100; dnd[2] = 16'h8000;
    cycle();
    chk("mis_pulse", mis, 1'b1);
    chk("mis_count", dcnt, 8'd2);
    dnv = '0;
    cycle();
    chk("mis_nodeliver", rx_v, 1'b0);
    chk("mis_clear", mis, 1'b0);
    dnv = 4'b0100;
    repeat (300) cycle();
    chk("sat_count", dcnt, 8'd255);
    dnv = '0;

    // Random traffic with occasional reset
    for (int c = 0; c < 2000; c++) begin
      reset    = ($urandom_range(0, 149) != 0);
      spine_en = 4'($urandom);
      tx_v     = 1'($urandom);
      tx_d     = 16'($urandom);
      rx_rdy   = ($urandom_range(0, 3) != 0);
      for (int n = 0; n < 4; n++) begin
        dnv[n] = ($urandom_range(0, 2) == 0);
        dnd[n] = ($urandom_range(0, 5) == 0) ? 16'($urandom)
                 : {MYD, 10'($urandom)};
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
